// File: rtl/dff_chain_ctrl.sv
// -----------------------------------------------------------------------------
// dff_chain_ctrl
//
// Sequencing controller for a serial chain of WIDTH D flip-flops. A START seen
// while idle latches LOAD_DATA and streams it into the chain LSB first, one bit
// per cycle, through SDO with SHIFT_EN held high for exactly WIDTH cycles. In
// the same cycles the chain's far-end output (CHAIN_IN) is captured, so the
// previous chain contents are returned on READ_DATA when the sequence ends.
//
// Ports:
//   CLK        in   1      clock, all state updates on the rising edge
//   RST        in   1      synchronous active-high reset
//   START      in   1      sequence request, only honoured in IDLE
//   LOAD_DATA  in   WIDTH  word shifted into the chain, latched on acceptance
//   CHAIN_IN   in   1      Q of the last chain stage
//   SHIFT_EN   out  1      chain shift enable
//   SDO        out  1      serial data to the first chain stage
//   BUSY       out  1      high whenever not IDLE
//   DONE       out  1      one-cycle completion pulse
//   READ_DATA  out  WIDTH  captured previous chain contents, held between runs
// -----------------------------------------------------------------------------
module dff_chain_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             CHAIN_IN,
  output logic             SHIFT_EN,
  output logic             SDO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] READ_DATA
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_read_data;
  logic [CW-1:0]    r_cnt;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic             w_shifting;
  logic [WIDTH-1:0] w_cap_next;

  assign w_last     = (r_cnt == CNT_LAST);
  assign w_shifting = (r_state == S_SHIFT);

  // One-hot write decode for the capture register: bit gi takes CHAIN_IN on
  // the SHIFT edge where the counter equals gi, otherwise it holds.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign w_cap_next[gi] = (w_shifting && (r_cnt == CW'(gi))) ? CHAIN_IN
                                                                 : r_cap[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cap <= '0;
    end else begin
      r_cap <= w_cap_next;
    end
  end

  // Control FSM. Status outputs are registered alongside the state so they
  // change only on clock edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_sr       <= LOAD_DATA;
            r_cnt      <= '0;
            r_state    <= S_SHIFT;
            r_shift_en <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_SHIFT: begin
          // Zero fill: after WIDTH shifts sr is all zero, which keeps SDO low
          // for the rest of the time without any extra gating.
          r_sr  <= {1'b0, r_sr[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state    <= S_FINISH;
            r_shift_en <= 1'b0;
            r_done     <= 1'b1;
          end
        end

        S_FINISH: begin
          r_read_data <= r_cap;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_sr       <= '0;
          r_cnt      <= '0;
          r_shift_en <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // SDO comes straight from a flop; sr is zero in IDLE and FINISH.
  assign SDO       = r_sr[0];
  assign SHIFT_EN  = r_shift_en;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign READ_DATA = r_read_data;

endmodule

// File: tb/tb_dff_chain_ctrl.sv
module tb_dff_chain_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] LOAD_DATA = '0;
  logic         CHAIN_IN;
  wire          SHIFT_EN;
  wire          SDO;
  wire          BUSY;
  wire          DONE;
  wire [W-1:0]  READ_DATA;

  always #5 CLK = ~CLK;

  dff_chain_ctrl #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LOAD_DATA (LOAD_DATA),
    .CHAIN_IN  (CHAIN_IN),
    .SHIFT_EN  (SHIFT_EN),
    .SDO       (SDO),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .READ_DATA (READ_DATA)
  );

  // Behavioural DFF chain: stage 0 takes SDO, last stage feeds CHAIN_IN.
  logic [W-1:0] chain = '0;
  logic         preload_req = 1'b0;
  logic [W-1:0] preload_val = '0;
  assign CHAIN_IN = chain[W-1];

  always @(posedge CLK) begin
    if (preload_req) chain <= preload_val;
    else if (SHIFT_EN === 1'b1) chain <= {chain[W-2:0], SDO};
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_chain = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rd = '0;

  // One full sequence. Called at a negedge; leaves at the negedge of cycle
  // WIDTH+2 with START set to 'hold'.
  task automatic run_seq(input logic [W-1:0] data, input int p1, input int p2,
                         input bit hold);
    logic [W-1:0] exp_rd;
    logic [W-1:0] got;
    int en_cnt;
    int done_cnt;
    for (int k = 0; k < W; k++) exp_rd[k] = exp_chain[W-1-k];
    exp_q.push_back(exp_rd);
    START = 1'b1;
    LOAD_DATA = data;
    en_cnt = 0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge CLK);
      if (!hold) START = (cyc == p1) || (cyc == p2);
      LOAD_DATA = ~data;
      if (SHIFT_EN === 1'b1) en_cnt++;
      if (DONE === 1'b1) done_cnt++;
      if (cyc <= W) begin
        checks++;
        if (SDO !== data[cyc-1]) begin
          failures++;
          $display("FAIL sdo_bit cyc=%0d got=%b exp=%b", cyc, SDO, data[cyc-1]);
        end
        checks++;
        if ({SHIFT_EN, BUSY, DONE} !== 3'b110) begin
          failures++;
          $display("FAIL shift_status cyc=%0d got=%b exp=110", cyc, {SHIFT_EN, BUSY, DONE});
        end
      end else begin
        checks++;
        if ({SHIFT_EN, BUSY, DONE, SDO} !== 4'b0110) begin
          failures++;
          $display("FAIL finish_status got=%b exp=0110", {SHIFT_EN, BUSY, DONE, SDO});
        end
      end
    end
    @(negedge CLK);
    checks++;
    if (en_cnt !== W) begin
      failures++;
      $display("FAIL shift_en_count got=%0d exp=%0d", en_cnt, W);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL done_count got=%0d exp=1", done_cnt);
    end
    checks++;
    if ({BUSY, DONE, SHIFT_EN} !== 3'b000) begin
      failures++;
      $display("FAIL idle_status got=%b exp=000", {BUSY, DONE, SHIFT_EN});
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=%h exp=none", READ_DATA);
    end else begin
      got = exp_q.pop_front();
      checks++;
      if (READ_DATA !== got) begin
        failures++;
        $display("FAIL read_data got=%h exp=%h", READ_DATA, got);
      end
      last_rd = got;
    end
    for (int j = 0; j < W; j++) exp_chain[j] = data[W-1-j];
    $display("seq load=%h read=%h shift_en_cycles=%0d done_pulses=%0d", data, READ_DATA, en_cnt, done_cnt);
    START = hold;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b1;
    LOAD_DATA = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({SHIFT_EN, SDO, BUSY, DONE} !== 4'b0000 || READ_DATA !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=%b/%h exp=0000/00", {SHIFT_EN, SDO, BUSY, DONE}, READ_DATA);
      end
    end
    RST = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    checks++;
    if ({SHIFT_EN, BUSY, DONE} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=000", {SHIFT_EN, BUSY, DONE});
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    run_seq(8'hA5, 0, 0, 1'b0);
    checks++;
    if (chain !== exp_chain) begin
      failures++;
      $display("FAIL chain_contents got=%h exp=%h", chain, exp_chain);
    end
  endtask

  task automatic test_readback();
    run_seq(8'h3C, 0, 0, 1'b0);
    checks++;
    if (chain !== exp_chain) begin
      failures++;
      $display("FAIL chain_contents_rb got=%h exp=%h", chain, exp_chain);
    end
  endtask

  task automatic test_busy_ignored();
    run_seq(8'h96, 3, 9, 1'b0);
    @(negedge CLK);
    checks++;
    if ({BUSY, SHIFT_EN} !== 2'b00) begin
      failures++;
      $display("FAIL start_not_queued got=%b exp=00", {BUSY, SHIFT_EN});
    end
  endtask

  task automatic test_abort();
    int done_seen;
    START = 1'b1;
    LOAD_DATA = 8'h5A;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    checks++;
    if (SHIFT_EN !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_shift got=%b exp=1", SHIFT_EN);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({SHIFT_EN, BUSY, DONE, SDO} !== 4'b0000 || READ_DATA !== '0) begin
      failures++;
      $display("FAIL abort_outputs got=%b/%h exp=0000/00", {SHIFT_EN, BUSY, DONE, SDO}, READ_DATA);
    end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    end
    $display("abort done read=%h", READ_DATA);
    // Chain is left partially shifted; give it a known value before rerunning.
    preload_val = 8'hC3;
    preload_req = 1'b1;
    @(negedge CLK);
    preload_req = 1'b0;
    exp_chain = 8'hC3;
    run_seq(8'h01, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq(8'h11, 0, 0, 1'b1);
    run_seq(8'h7E, 0, 0, 1'b1);
    run_seq(8'hF0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge CLK);
    checks++;
    if (READ_DATA !== last_rd || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL read_data_held got=%h/%b exp=%h/0", READ_DATA, BUSY, last_rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_busy_ignored();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_chain_ctrl.md
# dff_chain_ctrl

Sequencing controller for a serial chain of WIDTH edge-triggered D flip-flops clocked by CLK. On a start request it streams a parallel word into the chain one bit per cycle, LSB first, by driving the chain's serial input and shift enable. In the same cycles it captures the chain's previous contents from the chain's far-end output. It provides a load-and-readback register access point for the lab datapath, with BUSY/DONE status.

## Interface

Parameters:
- WIDTH, 8, number of DFF stages in the controlled chain and width of the data words; legal range 2..64

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  request a load/readback sequence; sampled only in IDLE
- LOAD_DATA  input  WIDTH  word to shift into the chain; latched on the accepted START edge
- CHAIN_IN  input  1  Q of the last chain stage, i.e. the chain's serial output
- SHIFT_EN  output  1  chain shift enable; chain advances one stage on each CLK edge where SHIFT_EN=1
- SDO  output  1  serial data to the first chain stage's D
- BUSY  output  1  high whenever the state is not IDLE
- DONE  output  1  one-cycle pulse marking sequence completion
- READ_DATA  output  WIDTH  previous chain contents captured during the sequence; held until the next sequence completes

## Operation

- Reset is synchronous and active-high. It is the only reset; no asynchronous path.
- Internal state: state (IDLE, SHIFT, FINISH), shift register sr[WIDTH-1:0], capture register cap[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH+1).
- IDLE:
  - SHIFT_EN=0, BUSY=0, DONE=0.
  - On an edge with START=1: sr<=LOAD_DATA, cnt<=0, state<=SHIFT.
- SHIFT:
  - SHIFT_EN=1, BUSY=1, SDO=sr[0].
  - Each edge: sr<=sr>>1 (zero fill), cap[cnt]<=CHAIN_IN, cnt<=cnt+1.
  - On the edge where cnt=WIDTH-1, state<=FINISH.
- FINISH:
  - SHIFT_EN=0, BUSY=1, DONE=1.
  - On the edge: READ_DATA<=cap, state<=IDLE.
- SDO outside SHIFT is 0. It is a registered/decoded function of state and sr and is glitch-free with respect to CLK.
- Bit mapping:
  - READ_DATA[k] = CHAIN_IN sampled on the k-th SHIFT edge (k=0..WIDTH-1). This is the old content of chain stage WIDTH-1-k, with stage 0 nearest SDO.
  - After completion, chain stage j holds LOAD_DATA[WIDTH-1-j].
- START while BUSY=1 (SHIFT or FINISH) is ignored and not queued.
- LOAD_DATA changes after acceptance have no effect on the running sequence.

## Timing

- Reset values: state=IDLE, SHIFT_EN=0, SDO=0, BUSY=0, DONE=0, READ_DATA=0, sr=0, cap=0, cnt=0.
- RST is asserted on edge E. From the cycle after E, outputs show reset values regardless of START.
- RST mid-SHIFT: sequence aborts, SHIFT_EN drops the next cycle, and READ_DATA is cleared to 0. The chain is left partially shifted; the controller does not restore it.
- RST has priority over START on the same edge.
- Cycle timeline, with START accepted on edge 0:
  - Cycles 1..WIDTH: SHIFT, with SHIFT_EN=1 for exactly WIDTH cycles.
  - Cycle WIDTH+1: FINISH, with DONE=1.
  - READ_DATA updates on edge WIDTH+1.
  - IDLE from cycle WIDTH+2.
- Back-to-back operation: a START held high is next accepted on edge WIDTH+2. Minimum period between sequences is WIDTH+2 cycles.
- DONE is high for exactly one cycle per accepted START and never asserted after an aborted sequence.
- The cnt terminal compare is against WIDTH-1; cnt never exceeds WIDTH-1 inside SHIFT.

## Test plan

- Reset: hold RST=1 for 2 cycles with START=1 and LOAD_DATA=8'hFF -> all outputs 0, BUSY=0, no SHIFT_EN pulse.
- Basic load, WIDTH=8, behavioural chain preloaded 8'h00, LOAD_DATA=8'hA5 -> SDO sequence 1,0,1,0,0,1,0,1 over 8 SHIFT_EN cycles. DONE pulses at cycle 9. READ_DATA=8'h00. Chain stages 0..7 hold 1,0,1,0,0,1,0,1.
- Readback: second sequence with LOAD_DATA=8'h3C -> READ_DATA=8'hA5, confirming the bit mapping. Chain now holds the bit-reverse of 8'h3C.
- START ignored while busy: pulse START on cycles 3 and 9 of a running sequence -> still exactly 8 SHIFT_EN cycles and a single DONE. No second sequence begins until START is seen in IDLE.
- Abort: RST at SHIFT cycle 4 -> SHIFT_EN=0 and BUSY=0 the next cycle, DONE never asserts, READ_DATA=0. A following START with LOAD_DATA=8'h01 completes normally in 10 cycles.
- Back-to-back: START held high continuously -> sequences start every 10 cycles (WIDTH+2). DONE pulses at cycles 9, 19, 29. SHIFT_EN duty is 8 of every 10 cycles.
